// File: rtl/cpu_control_unit.sv
// Fetch-decode-execute sequencer for the 16-bit accumulator CPU.
// Define CPU_ILLEGAL_TRAP_EN to trap undefined opcodes into HALT and raise the 'illegal' output.
module cpu_control_unit #(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] ir_opcode,
    input  logic [1:0] ir_cond,
    input  logic       ac_zero,
    input  logic       ac_neg,
    output logic       mar_load,
    output logic       mar_src,
    output logic       mem_re,
    output logic       mem_we,
    output logic       mbr_load,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       ac_load,
    output logic       ac_src,
    output logic [3:0] alu_op,
    output logic       halted,
`ifdef CPU_ILLEGAL_TRAP_EN
    output logic       illegal,
`endif
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        F_MAR  = 4'd1,
        F_RD   = 4'd2,
        F_IR   = 4'd3,
        DECODE = 4'd4,
        X_RD   = 4'd5,
        X_MBR  = 4'd6,
        X_EX   = 4'd7,
        X_WR   = 4'd8,
        HALT   = 4'd9
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUBT  = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h7;
    localparam logic [3:0] OP_SKIP  = 4'h8;
    localparam logic [3:0] OP_JUMP  = 4'h9;
    localparam logic [1:0] WAIT_LAST = 2'(MEM_LAT - 1);

    state_t     state_q, state_d;
    logic [1:0] wait_q, wait_d;
    logic [3:0] op_q, op_d;
    logic       skip;
    logic       illegal_d, illegal_q;

    always_comb begin
        skip = ((ir_cond == 2'b00) && ac_neg) ||
               ((ir_cond == 2'b01) && ac_zero) ||
               ((ir_cond == 2'b10) && !ac_neg && !ac_zero);
    end

    // The wait counter is shared by both read windows and is zero whenever we are not counting.
    always_comb begin
        state_d   = state_q;
        wait_d    = 2'd0;
        op_d      = op_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE:   if (start) state_d = F_MAR;
            F_MAR:  state_d = F_RD;
            F_RD:   if (wait_q == WAIT_LAST) state_d = F_IR;
                    else wait_d = wait_q + 2'd1;
            F_IR:   state_d = DECODE;
            DECODE: begin
                op_d = ir_opcode;
                case (ir_opcode)
                    OP_LOAD, OP_ADD, OP_SUBT: state_d = X_RD;
                    OP_STORE:                 state_d = X_WR;
                    OP_HALT:                  state_d = HALT;
                    OP_SKIP, OP_JUMP:         state_d = F_MAR;
                    default: begin
`ifdef CPU_ILLEGAL_TRAP_EN
                        state_d   = HALT;
                        illegal_d = 1'b1;
`else
                        state_d   = F_MAR;
`endif
                    end
                endcase
            end
            X_RD:   if (wait_q == WAIT_LAST) state_d = X_MBR;
                    else wait_d = wait_q + 2'd1;
            X_MBR:  state_d = X_EX;
            X_EX:   state_d = F_MAR;
            X_WR:   state_d = F_MAR;
            HALT:   state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            wait_q    <= 2'd0;
            op_q      <= 4'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    // Strobes decode the registered state only; DECODE also looks at the freshly loaded IR fields.
    always_comb begin
        mar_load = 1'b0;
        mar_src  = 1'b0;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        mbr_load = 1'b0;
        ir_load  = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        ac_load  = 1'b0;
        ac_src   = 1'b0;
        alu_op   = 4'b0000;
        halted   = 1'b0;
        case (state_q)
            F_MAR:       mar_load = 1'b1;
            F_RD, X_RD:  mem_re   = 1'b1;
            F_IR: begin
                ir_load = 1'b1;
                pc_inc  = 1'b1;
            end
            DECODE: begin
                case (ir_opcode)
                    OP_LOAD, OP_ADD, OP_SUBT, OP_STORE: begin
                        mar_load = 1'b1;
                        mar_src  = 1'b1;
                    end
                    OP_SKIP: pc_inc  = skip;
                    OP_JUMP: pc_load = 1'b1;
                    default: ;
                endcase
            end
            X_MBR:       mbr_load = 1'b1;
            X_EX: begin
                ac_load = 1'b1;
                ac_src  = (op_q != OP_LOAD);
                alu_op  = (op_q == OP_SUBT) ? 4'b0001 : 4'b0000;
            end
            X_WR:        mem_we = 1'b1;
            HALT:        halted = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;
`ifdef CPU_ILLEGAL_TRAP_EN
    assign illegal = illegal_q;
`endif

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: one instance at MEM_LAT=1 and one at MEM_LAT=3.
// Expected strobe/state sequences are hand-built per instruction; CPU_ILLEGAL_TRAP_EN selects the trap variant.
module tb_cpu_control_unit;

    localparam logic [3:0] ST_IDLE = 4'd0, ST_FMAR = 4'd1, ST_FRD = 4'd2, ST_FIR = 4'd3,
                           ST_DEC  = 4'd4, ST_XRD  = 4'd5, ST_XMBR = 4'd6, ST_XEX = 4'd7,
                           ST_XWR  = 4'd8, ST_HALT = 4'd9;

    // Strobe word: mar_load mar_src mem_re mem_we mbr_load ir_load pc_inc pc_load ac_load ac_src alu_op[3:0] halted
    localparam logic [14:0] V_0     = 15'h0000;
    localparam logic [14:0] V_MARPC = 15'h4000;
    localparam logic [14:0] V_MARIR = 15'h6000;
    localparam logic [14:0] V_RE    = 15'h1000;
    localparam logic [14:0] V_WE    = 15'h0800;
    localparam logic [14:0] V_MBR   = 15'h0400;
    localparam logic [14:0] V_IRL   = 15'h0300;
    localparam logic [14:0] V_INC   = 15'h0100;
    localparam logic [14:0] V_PCL   = 15'h0080;
    localparam logic [14:0] V_ACM   = 15'h0040;
    localparam logic [14:0] V_ADD   = 15'h0060;
    localparam logic [14:0] V_SUB   = 15'h0062;
    localparam logic [14:0] V_HLT   = 15'h0001;

    logic clk = 1'b0;
    logic rst_a, rst_b, start_a, start_b;
    logic [15:0] ir_word;
    logic ac_neg, ac_zero;

    logic mar_load_a, mar_src_a, mem_re_a, mem_we_a, mbr_load_a, ir_load_a;
    logic pc_inc_a, pc_load_a, ac_load_a, ac_src_a, halted_a;
    logic [3:0] alu_op_a, state_a;
    logic mar_load_b, mar_src_b, mem_re_b, mem_we_b, mbr_load_b, ir_load_b;
    logic pc_inc_b, pc_load_b, ac_load_b, ac_src_b, halted_b;
    logic [3:0] alu_op_b, state_b;
`ifdef CPU_ILLEGAL_TRAP_EN
    logic illegal_a, illegal_b;
`endif

    logic [18:0] vec_a, vec_b;
    logic [18:0] expected_list[$];
    int n_checks = 0;
    int n_fails = 0;

    always #5 clk = ~clk;

    cpu_control_unit #(.MEM_LAT(1)) dut_a (
        .clk(clk), .reset(rst_a), .start(start_a),
        .ir_opcode(ir_word[15:12]), .ir_cond(ir_word[11:10]),
        .ac_zero(ac_zero), .ac_neg(ac_neg),
        .mar_load(mar_load_a), .mar_src(mar_src_a), .mem_re(mem_re_a), .mem_we(mem_we_a),
        .mbr_load(mbr_load_a), .ir_load(ir_load_a), .pc_inc(pc_inc_a), .pc_load(pc_load_a),
        .ac_load(ac_load_a), .ac_src(ac_src_a), .alu_op(alu_op_a), .halted(halted_a),
`ifdef CPU_ILLEGAL_TRAP_EN
        .illegal(illegal_a),
`endif
        .state(state_a)
    );

    cpu_control_unit #(.MEM_LAT(3)) dut_b (
        .clk(clk), .reset(rst_b), .start(start_b),
        .ir_opcode(ir_word[15:12]), .ir_cond(ir_word[11:10]),
        .ac_zero(ac_zero), .ac_neg(ac_neg),
        .mar_load(mar_load_b), .mar_src(mar_src_b), .mem_re(mem_re_b), .mem_we(mem_we_b),
        .mbr_load(mbr_load_b), .ir_load(ir_load_b), .pc_inc(pc_inc_b), .pc_load(pc_load_b),
        .ac_load(ac_load_b), .ac_src(ac_src_b), .alu_op(alu_op_b), .halted(halted_b),
`ifdef CPU_ILLEGAL_TRAP_EN
        .illegal(illegal_b),
`endif
        .state(state_b)
    );

    assign vec_a = {state_a, mar_load_a, mar_src_a, mem_re_a, mem_we_a, mbr_load_a, ir_load_a,
                    pc_inc_a, pc_load_a, ac_load_a, ac_src_a, alu_op_a, halted_a};
    assign vec_b = {state_b, mar_load_b, mar_src_b, mem_re_b, mem_we_b, mbr_load_b, ir_load_b,
                    pc_inc_b, pc_load_b, ac_load_b, ac_src_b, alu_op_b, halted_b};

    task automatic checkOutput(input string tag, input logic [18:0] observed, input logic [18:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got state=%0d strobes=%h, expected state=%0d strobes=%h",
                     tag, observed[18:15], observed[14:0], expected[18:15], expected[14:0]);
        end
    endtask

    task automatic pushExpected(input logic [3:0] st, input logic [14:0] v);
        expected_list.push_back({st, v});
    endtask

    task automatic pushFetch(input int lat);
        pushExpected(ST_FMAR, V_MARPC);
        for (int k = 0; k < lat; k++) pushExpected(ST_FRD, V_RE);
        pushExpected(ST_FIR, V_IRL);
    endtask

    task automatic pushMemOp(input int lat, input logic [14:0] ex);
        pushExpected(ST_DEC, V_MARIR);
        for (int k = 0; k < lat; k++) pushExpected(ST_XRD, V_RE);
        pushExpected(ST_XMBR, V_MBR);
        pushExpected(ST_XEX, ex);
    endtask

    // Walks one instruction cycle by cycle; IR and AC flags change only in the F_MAR cycle.
    task automatic applyStimulus(input bit use_b, input string tag, input logic [15:0] ir,
                                 input logic neg, input logic zero);
        for (int i = 0; i < expected_list.size(); i++) begin
            @(negedge clk);
            checkOutput($sformatf("%s[%0d]", tag, i), use_b ? vec_b : vec_a, expected_list[i]);
            if (i == 0) begin
                start_a = 1'b0;
                start_b = 1'b0;
                ir_word = ir;
                ac_neg  = neg;
                ac_zero = zero;
            end
        end
        expected_list.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        ir_word = 16'h0000; ac_neg = 1'b0; ac_zero = 1'b0;

        @(negedge clk);
        checkOutput("reset_a", vec_a, {ST_IDLE, V_0});
        checkOutput("reset_b", vec_b, {ST_IDLE, V_0});
        rst_a = 1'b0;
        @(negedge clk);
        checkOutput("idle_a", vec_a, {ST_IDLE, V_0});

        start_a = 1'b1;
        pushFetch(1); pushMemOp(1, V_ACM);
        applyStimulus(0, "load", 16'h1005, 1'b0, 1'b0);

        pushFetch(1); pushExpected(ST_DEC, V_MARIR); pushExpected(ST_XWR, V_WE);
        applyStimulus(0, "store", 16'h2020, 1'b0, 1'b0);

        pushFetch(1); pushExpected(ST_DEC, V_INC);
        applyStimulus(0, "skip_neg", 16'h8000, 1'b1, 1'b0);
        pushFetch(1); pushExpected(ST_DEC, V_0);
        applyStimulus(0, "skip_zero_no", 16'h8400, 1'b0, 1'b0);
        pushFetch(1); pushExpected(ST_DEC, V_INC);
        applyStimulus(0, "skip_pos", 16'h8800, 1'b0, 1'b0);
        pushFetch(1); pushExpected(ST_DEC, V_0);
        applyStimulus(0, "skip_never", 16'h8C00, 1'b1, 1'b1);

        pushFetch(1); pushExpected(ST_DEC, V_PCL);
        applyStimulus(0, "jump", 16'h9ABC, 1'b0, 1'b0);

        pushFetch(1); pushExpected(ST_DEC, V_0);
        pushExpected(ST_HALT, V_HLT); pushExpected(ST_HALT, V_HLT);
        applyStimulus(0, "halt", 16'h7000, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            start_a = 1'b1;
            @(negedge clk);
            checkOutput("halt_start", vec_a, {ST_HALT, V_HLT});
            start_a = 1'b0;
            @(negedge clk);
            checkOutput("halt_hold", vec_a, {ST_HALT, V_HLT});
        end

        rst_a = 1'b1;
        #1 checkOutput("reset_from_halt", vec_a, {ST_IDLE, V_0});
        @(negedge clk);
        rst_a = 1'b0;
        start_a = 1'b1;
        pushFetch(1); pushExpected(ST_DEC, V_MARIR); pushExpected(ST_XRD, V_RE);
        applyStimulus(0, "abort_pre", 16'h1005, 1'b0, 1'b0);
        rst_a = 1'b1;
        #1 checkOutput("abort_async", vec_a, {ST_IDLE, V_0});
        @(negedge clk);
        checkOutput("abort_idle", vec_a, {ST_IDLE, V_0});
        rst_a = 1'b0;

        start_a = 1'b1;
        pushFetch(1); pushExpected(ST_DEC, V_0);
`ifdef CPU_ILLEGAL_TRAP_EN
        pushExpected(ST_HALT, V_HLT);
`else
        pushExpected(ST_FMAR, V_MARPC);
`endif
        applyStimulus(0, "opcode_b", 16'hB000, 1'b0, 1'b0);
`ifdef CPU_ILLEGAL_TRAP_EN
        checkOutput("illegal_flag", {18'd0, illegal_a}, 19'd1);
`endif

        rst_a = 1'b1;
        rst_b = 1'b0;
        @(negedge clk);
        start_b = 1'b1;
        pushFetch(3); pushMemOp(3, V_ADD);
        applyStimulus(1, "add_lat3", 16'h3010, 1'b0, 1'b0);
        pushFetch(3); pushMemOp(3, V_SUB);
        applyStimulus(1, "subt_lat3", 16'h4010, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("after_subt", vec_b, {ST_FMAR, V_MARPC});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
